// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, register IDs and
// the encoding of the pipeline controller's state.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_HLT = 4'h2;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] STAT_INS = 4'h4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    CPU_FLUSH  = 2'd0,
    CPU_RUN    = 2'd1,
    CPU_HALTED = 2'd2
  } cpu_state_t;

  // Stage-register controls, grouped so the output mux assigns them as one value.
  typedef struct packed {
    logic f_stall;
    logic d_stall;
    logic w_stall;
    logic d_bubble;
    logic e_bubble;
    logic m_bubble;
    logic set_cc;
  } pipe_ctrl_t;

  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == STAT_HLT) || (stat == STAT_ADR) || (stat == STAT_INS);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the stage registers and pipe_ctrl: decoded stage fields in,
// stall/bubble controls, processor state and performance counters out.
interface pipe_ctrl_if;
  import y86_pkg::*;

  logic [3:0]  D_icode;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [3:0]  E_icode;
  logic [3:0]  E_dstM;
  logic        e_Cnd;
  logic [3:0]  M_icode;
  logic [3:0]  m_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_stat;

  logic        F_stall;
  logic        D_stall;
  logic        W_stall;
  logic        D_bubble;
  logic        E_bubble;
  logic        M_bubble;
  logic        set_cc;
  cpu_state_t  cpu_state;
  logic [3:0]  final_stat;
  logic [63:0] cycle_cnt;
  logic [63:0] instr_cnt;

  // Controller side.
  modport master (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_stat, W_icode, W_stat,
    output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
           set_cc, cpu_state, final_stat, cycle_cnt, instr_cnt
  );

  // Stage-register side.
  modport slave (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_stat, W_icode, W_stat,
    input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
           set_cc, cpu_state, final_stat, cycle_cnt, instr_cnt
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Purely combinational hazard classification for the Y86-64 pipeline:
// load/use, branch mispredict, return in flight and memory/write-back exceptions.
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [3:0] m_stat,
  input  logic [3:0] W_stat,
  output logic       loaduse,
  output logic       mispred,
  output logic       retp,
  output logic       exc_m,
  output logic       exc_w
);

  logic e_is_load;

  assign e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);

  // A REG_NONE destination never matches, even if a source is also REG_NONE.
  assign loaduse = e_is_load && (E_dstM != REG_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  assign mispred = (E_icode == I_JXX) && !e_Cnd;
  assign retp    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign exc_m   = is_exc(m_stat);
  assign exc_w   = is_exc(W_stat);

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: post-reset flush, stall/bubble generation, halt latch
// and optional performance counters (enabled by defining PIPE_CTRL_PERF_EN).
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  pipe_ctrl_if.master    bus
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  localparam pipe_ctrl_t CTRL_FLUSH = '{f_stall: 1'b1, d_stall: 1'b0, w_stall: 1'b0,
                                        d_bubble: 1'b1, e_bubble: 1'b1, m_bubble: 1'b1,
                                        set_cc: 1'b0};
  localparam pipe_ctrl_t CTRL_HALT  = '{f_stall: 1'b1, d_stall: 1'b1, w_stall: 1'b1,
                                        d_bubble: 1'b0, e_bubble: 1'b1, m_bubble: 1'b1,
                                        set_cc: 1'b0};

  cpu_state_t state;
  logic [3:0] flush_cnt;
  logic [3:0] final_stat;
  pipe_ctrl_t ctrl;

  logic loaduse, mispred, retp, exc_m, exc_w;

  pipe_hazard_detect u_hazard (
    .D_icode (bus.D_icode),
    .d_srcA  (bus.d_srcA),
    .d_srcB  (bus.d_srcB),
    .E_icode (bus.E_icode),
    .E_dstM  (bus.E_dstM),
    .e_Cnd   (bus.e_Cnd),
    .M_icode (bus.M_icode),
    .m_stat  (bus.m_stat),
    .W_stat  (bus.W_stat),
    .loaduse (loaduse),
    .mispred (mispred),
    .retp    (retp),
    .exc_m   (exc_m),
    .exc_w   (exc_w)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CPU_FLUSH;
      flush_cnt  <= '0;
      final_stat <= '0;
    end else begin
      unique case (state)
        CPU_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) state <= CPU_RUN;
          else                         flush_cnt <= flush_cnt + 4'd1;
        end
        CPU_RUN: begin
          if (exc_w) begin
            state      <= CPU_HALTED;
            final_stat <= bus.W_stat;
          end
        end
        CPU_HALTED: ;
        default: state <= CPU_FLUSH;
      endcase
    end
  end

  // The stage registers have no reset, so reset itself must present flush controls.
  // NOTE: ctrl gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ctrl = CTRL_FLUSH;
    if (!rst) begin
      unique case (state)
        CPU_RUN: begin
          ctrl.f_stall  = loaduse || retp;
          ctrl.d_stall  = loaduse;
          ctrl.w_stall  = exc_w;
          ctrl.d_bubble = mispred || (retp && !loaduse);
          ctrl.e_bubble = mispred || loaduse;
          ctrl.m_bubble = exc_m || exc_w;
          ctrl.set_cc   = (bus.E_icode == I_OPQ) && !exc_m && !exc_w;
        end
        CPU_HALTED: ctrl = CTRL_HALT;
        default:    ctrl = CTRL_FLUSH;
      endcase
    end
  end

  assign bus.F_stall    = ctrl.f_stall;
  assign bus.D_stall    = ctrl.d_stall;
  assign bus.W_stall    = ctrl.w_stall;
  assign bus.D_bubble   = ctrl.d_bubble;
  assign bus.E_bubble   = ctrl.e_bubble;
  assign bus.M_bubble   = ctrl.m_bubble;
  assign bus.set_cc     = ctrl.set_cc;
  assign bus.cpu_state  = state;
  assign bus.final_stat = final_stat;

`ifdef PIPE_CTRL_PERF_EN
  logic [63:0] cycle_q;
  logic [63:0] instr_q;

  // An excepting instruction carries a non-AOK status, so it is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (state == CPU_RUN) begin
      cycle_q <= cycle_q + 64'd1;
      if ((bus.W_stat == STAT_AOK) && (bus.W_icode != I_NOP))
        instr_q <= instr_q + 64'd1;
    end
  end

  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;
`else
  assign bus.cycle_cnt = '0;
  assign bus.instr_cnt = '0;
`endif

endmodule
